// File: rtl/weight_replay_buf.sv
// Kernel replay buffer: loads KERN_S coefficients, then streams them N_REPLAY times to the MAC.
// First output follows the last load write by one cycle; output stalls hold all state, input is closed during replay.
module weight_replay_buf #(
   parameter int COEFF_W  = 16,
   parameter int KERN_S   = 288,
   parameter int N_REPLAY = 4
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   input  logic [COEFF_W-1:0] input_V_din,
   output logic               input_V_full_n,
   input  logic               input_V_write,
   output logic [COEFF_W-1:0] output_V_din,
   input  logic               output_V_full_n,
   output logic               output_V_write,
   output logic               kern_done,
   output logic               proto_err
);
   localparam int IW = (KERN_S > 1) ? $clog2(KERN_S) : 1;
   localparam int PW = (N_REPLAY > 1) ? $clog2(N_REPLAY) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(KERN_S - 1);
   localparam logic [PW-1:0] LAST_PASS = PW'(N_REPLAY - 1);

   typedef enum logic {LOAD = 1'b0, PLAY = 1'b1} state_t;

   state_t             state;
   logic [IW-1:0]      wr_idx;
   logic [IW-1:0]      rd_idx;
   logic [PW-1:0]      pass;
   logic [COEFF_W-1:0] mem [KERN_S];

   logic load_wr;
   logic play_adv;
   logic last_coeff;

   assign load_wr    = (state == LOAD) && input_V_write;
   assign play_adv   = (state == PLAY) && output_V_full_n;
   assign last_coeff = (rd_idx == LAST_IDX) && (pass == LAST_PASS);

   // Register file is deliberately left out of reset; contents are only read after a full load.
   always_ff @(posedge ap_clk) begin
      if (load_wr) begin
         mem[wr_idx] <= input_V_din;
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state     <= LOAD;
         wr_idx    <= '0;
         rd_idx    <= '0;
         pass      <= '0;
         proto_err <= 1'b0;
      end else begin
         if (input_V_write && (state == PLAY)) begin
            proto_err <= 1'b1;
         end
         case (state)
            LOAD: begin
               if (input_V_write) begin
                  if (wr_idx == LAST_IDX) begin
                     wr_idx <= '0;
                     state  <= PLAY;
                  end else begin
                     wr_idx <= wr_idx + 1'b1;
                  end
               end
            end
            PLAY: begin
               if (output_V_full_n) begin
                  if (rd_idx == LAST_IDX) begin
                     rd_idx <= '0;
                     if (pass == LAST_PASS) begin
                        pass  <= '0;
                        state <= LOAD;
                     end else begin
                        pass <= pass + 1'b1;
                     end
                  end else begin
                     rd_idx <= rd_idx + 1'b1;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   // Outputs depend only on state and downstream room, never on the upstream write path.
   assign input_V_full_n = (state == LOAD);
   assign output_V_write = play_adv;
   assign output_V_din   = (state == PLAY) ? mem[rd_idx] : '0;
   assign kern_done      = play_adv && last_coeff;

endmodule

// File: tb/tb_weight_replay_buf.sv
// Bench for weight_replay_buf: small (4x2) instance for directed cases, default instance for random stalls.
module tb_weight_replay_buf;

   int checks   = 0;
   int failures = 0;

   logic        clk;
   logic        rst    [2];
   logic        in_wr  [2];
   logic [15:0] in_din [2];
   logic        ofn    [2];
   logic        ifn    [2];
   logic        ow     [2];
   logic [15:0] od     [2];
   logic        kd     [2];
   logic        pe     [2];

   // Reference model: kernel contents plus a count of outputs still owed.
   int          kk     [2];
   int          nn     [2];
   logic [15:0] kern   [2][288];
   int          m_ld   [2];
   int          m_pos  [2];
   int          m_tot  [2];
   int          m_done [2];
   int          kd_seen[2];
   logic        m_pe   [2];

   weight_replay_buf #(.COEFF_W(16), .KERN_S(4), .N_REPLAY(2)) dut_small (
      .ap_clk(clk), .ap_rst(rst[0]),
      .input_V_din(in_din[0]), .input_V_full_n(ifn[0]), .input_V_write(in_wr[0]),
      .output_V_din(od[0]), .output_V_full_n(ofn[0]), .output_V_write(ow[0]),
      .kern_done(kd[0]), .proto_err(pe[0])
   );

   weight_replay_buf #(.COEFF_W(16), .KERN_S(288), .N_REPLAY(4)) dut_dflt (
      .ap_clk(clk), .ap_rst(rst[1]),
      .input_V_din(in_din[1]), .input_V_full_n(ifn[1]), .input_V_write(in_wr[1]),
      .output_V_din(od[1]), .output_V_full_n(ofn[1]), .output_V_write(ow[1]),
      .kern_done(kd[1]), .proto_err(pe[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input int u, input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL u%0d %s observed=%0h expected=%0h", u, tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int u);
      m_ld[u]  = 0;
      m_pos[u] = 0;
      m_tot[u] = 0;
      m_pe[u]  = 1'b0;
   endtask

   task automatic chk_reset(input int u, input string tag);
      chk(u, {tag, "_in_full_n"}, 32'(ifn[u]), 32'd1);
      chk(u, {tag, "_out_write"}, 32'(ow[u]), 32'd0);
      chk(u, {tag, "_out_din"},   32'(od[u]), 32'd0);
      chk(u, {tag, "_kern_done"}, 32'(kd[u]), 32'd0);
      chk(u, {tag, "_proto_err"}, 32'(pe[u]), 32'd0);
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic tick(input int u, input logic wr, input logic [15:0] d, input logic of);
      logic        playing;
      logic        ew;
      logic        ekd;
      logic [15:0] ed;
      in_wr[u]  = wr;
      in_din[u] = d;
      ofn[u]    = of;
      #1;
      playing = (m_tot[u] != 0);
      ew      = playing && of;
      ed      = playing ? kern[u][m_pos[u] % kk[u]] : 16'h0;
      ekd     = ew && (m_pos[u] == m_tot[u] - 1);
      chk(u, "in_full_n", 32'(ifn[u]), 32'(!playing));
      chk(u, "out_write", 32'(ow[u]),  32'(ew));
      chk(u, "out_din",   32'(od[u]),  32'(ed));
      chk(u, "kern_done", 32'(kd[u]),  32'(ekd));
      chk(u, "proto_err", 32'(pe[u]),  32'(m_pe[u]));
      if (kd[u] === 1'b1) kd_seen[u]++;
      if (playing) begin
         if (wr) m_pe[u] = 1'b1;
         if (of) begin
            m_pos[u]++;
            if (m_pos[u] == m_tot[u]) begin
               m_tot[u] = 0;
               m_pos[u] = 0;
               m_done[u]++;
            end
         end
      end else if (wr) begin
         kern[u][m_ld[u]] = d;
         m_ld[u]++;
         if (m_ld[u] == kk[u]) begin
            m_ld[u]  = 0;
            m_pos[u] = 0;
            m_tot[u] = kk[u] * nn[u];
         end
      end
      @(negedge clk);
   endtask

   task automatic drain(input int u);
      for (int i = 0; i < 64 && m_tot[u] != 0; i++) tick(u, 1'b0, 16'h0, 1'b1);
   endtask

   task automatic load_small(input logic [15:0] base);
      for (int i = 0; i < 4; i++) tick(0, 1'b1, base + 16'(i), 1'b1);
   endtask

   task automatic reset_mid(input int u);
      #2;
      in_wr[u] = 1'b0;
      rst[u]   = 1'b1;
      #1;
      model_reset(u);
      chk_reset(u, "async_rst");
      @(negedge clk);
      rst[u] = 1'b0;
   endtask

   initial begin
      int  cyc;
      logic loading;
      kk[0] = 4;   nn[0] = 2;
      kk[1] = 288; nn[1] = 4;
      for (int u = 0; u < 2; u++) begin
         rst[u] = 1'b0; in_wr[u] = 1'b0; in_din[u] = 16'h0; ofn[u] = 1'b1;
         m_done[u] = 0; kd_seen[u] = 0;
         model_reset(u);
      end
      #1;
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      #1;
      chk_reset(0, "init");
      chk_reset(1, "init");
      @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      // T1: back-to-back load, free-running output
      load_small(16'd1);
      for (int i = 0; i < 8; i++) tick(0, 1'b0, 16'h0, 1'b1);

      // T2: alternating downstream backpressure
      load_small(16'd11);
      for (int i = 0; i < 16; i++) tick(0, 1'b0, 16'h0, (i % 2) == 0);
      drain(0);

      // T3: upstream writes on alternate cycles
      for (int i = 0; i < 4; i++) begin
         tick(0, 1'b1, 16'd20 + 16'(i), 1'b1);
         tick(0, 1'b0, 16'h0, 1'b1);
      end
      drain(0);

      // T4: illegal writes during replay, then a clean reload
      load_small(16'd21);
      tick(0, 1'b0, 16'h0, 1'b1);
      tick(0, 1'b1, 16'd9, 1'b1);
      tick(0, 1'b1, 16'd9, 1'b0);
      drain(0);
      load_small(16'd5);
      drain(0);

      // T5: reset after three outputs
      load_small(16'd31);
      for (int i = 0; i < 3; i++) tick(0, 1'b0, 16'h0, 1'b1);
      reset_mid(0);
      load_small(16'd41);
      drain(0);
      chk(0, "kern_done_count", 32'(kd_seen[0]), 32'(m_done[0]));

      // T6: default sizes, three kernels, random gaps and stalls
      cyc = 0;
      while (m_done[1] < 3 && cyc < 20000) begin
         loading = (m_tot[1] == 0);
         tick(1, loading && ($urandom_range(0, 3) != 0), 16'($urandom), $urandom_range(0, 2) != 0);
         cyc++;
      end
      chk(1, "kernels_in_budget", 32'(m_done[1]), 32'd3);
      chk(1, "kern_done_count",   32'(kd_seen[1]), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
